// File: rtl/sweep_pkg.sv
// Shared types and MISR constants for the exhaustive-sweep sequencer.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    EMIT,
    DONE
  } sweep_state_t;

  localparam logic [15:0] SIG_POLY = 16'h1021;
  localparam logic [15:0] SIG_SEED = 16'hFFFF;

  // One MISR step: CRC-16 style shift with feedback, then fold in the new response.
  function automatic logic [15:0] misr_next(input logic [15:0] sig, input logic [15:0] data);
    return ({sig[14:0], 1'b0} ^ (sig[15] ? SIG_POLY : 16'h0000)) ^ data;
  endfunction

endpackage

// File: rtl/sweep_misr.sv
// 16-bit multiple-input signature register; load seeds it, shift folds in one record.
module sweep_misr
  import sweep_pkg::*;
(
  input  logic        clk,
  input  logic        srst,
  input  logic        load_en_i,
  input  logic        shift_en_i,
  input  logic [15:0] data_i,
  output logic [15:0] sig_o
);

  logic [15:0] sig_q;
  logic [15:0] sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load_en_i) begin
      sig_d = SIG_SEED;
    end else if (shift_en_i) begin
      sig_d = misr_next(sig_q, data_i);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sig_q <= '0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/trojan_sweep_sequencer.sv
// Exhaustive stimulus sweep of a small CUT, streaming (vector, response) records.
// Optional macro SWEEP_SIGNATURE_EN adds a MISR signature over all responses.
module trojan_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int N_WIDTH       = 4,
  parameter int OUT_WIDTH     = 1,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [N_WIDTH-1:0]   cut_in,
  input  logic [OUT_WIDTH-1:0] cut_out,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [N_WIDTH-1:0]   rec_vector,
  output logic [OUT_WIDTH-1:0] rec_response
`ifdef SWEEP_SIGNATURE_EN
  ,
  output logic [15:0]          signature,
  output logic                 sig_valid
`endif
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (N_WIDTH < 1 || N_WIDTH > 16 || OUT_WIDTH < 1 || OUT_WIDTH > 16) begin : g_bad_width
    $error("N_WIDTH and OUT_WIDTH must be in 1..16");
  end

  sweep_state_t           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [N_WIDTH-1:0]     cut_in_q, cut_in_d;
  logic                   rec_valid_q, rec_valid_d;
  logic [N_WIDTH-1:0]     rec_vector_q, rec_vector_d;
  logic [OUT_WIDTH-1:0]   rec_response_q, rec_response_d;
  logic                   done_q, done_d;

  logic start_accept;
  logic handshake;

  assign start_accept = (state_q == IDLE) && start;
  assign handshake    = (state_q == EMIT) && rec_valid_q && rec_ready;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    cut_in_d       = cut_in_q;
    rec_valid_d    = rec_valid_q;
    rec_vector_d   = rec_vector_q;
    rec_response_d = rec_response_q;
    done_d         = 1'b0;
    // abort overrides every state, including a pending handshake
    if (abort) begin
      state_d     = IDLE;
      rec_valid_d = 1'b0;
      cut_in_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_accept) begin
            state_d  = SETTLE;
            cut_in_d = '0;
            cnt_d    = CNT_RELOAD;
          end
        end
        SETTLE: begin
          if (cnt_q == '0) begin
            state_d = CAPTURE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        CAPTURE: begin
          rec_response_d = cut_out;
          rec_vector_d   = cut_in_q;
          rec_valid_d    = 1'b1;
          state_d        = EMIT;
        end
        EMIT: begin
          if (handshake) begin
            rec_valid_d = 1'b0;
            // terminating on all-ones keeps the vector from ever wrapping
            if (&cut_in_q) begin
              state_d = DONE;
            end else begin
              cut_in_d = cut_in_q + 1'b1;
              cnt_d    = CNT_RELOAD;
              state_d  = SETTLE;
            end
          end
        end
        DONE: begin
          done_d   = 1'b1;
          cut_in_d = '0;
          state_d  = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      cut_in_q       <= '0;
      rec_valid_q    <= 1'b0;
      rec_vector_q   <= '0;
      rec_response_q <= '0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cut_in_q       <= cut_in_d;
      rec_valid_q    <= rec_valid_d;
      rec_vector_q   <= rec_vector_d;
      rec_response_q <= rec_response_d;
      done_q         <= done_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign cut_in       = cut_in_q;
  assign rec_valid    = rec_valid_q;
  assign rec_vector   = rec_vector_q;
  assign rec_response = rec_response_q;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] resp_ext;
  logic        sig_valid_q;

  always_comb begin
    resp_ext                  = '0;
    resp_ext[OUT_WIDTH-1:0]   = rec_response_q;
  end

  sweep_misr u_misr (
    .clk        (CK),
    .srst       (reset),
    .load_en_i  (start_accept && !abort),
    .shift_en_i (handshake && !abort),
    .data_i     (resp_ext),
    .sig_o      (signature)
  );

  // set in the same cycle done_q is loaded so both rise together
  always_ff @(posedge CK) begin
    if (reset) begin
      sig_valid_q <= 1'b0;
    end else if (abort || start_accept) begin
      sig_valid_q <= 1'b0;
    end else if (state_q == DONE) begin
      sig_valid_q <= 1'b1;
    end
  end

  assign sig_valid = sig_valid_q;
`endif

endmodule

// File: tb/tb_trojan_sweep_sequencer.sv
// Directed bench: full sweeps, backpressure, abort, reset mid-sweep, registered CUT.
module tb_trojan_sweep_sequencer;

  logic       CK;
  logic       reset, start, abort, rec_ready;
  logic       busy, done, rec_valid;
  logic [3:0] cut_in, rec_vector;
  logic [0:0] cut_out, rec_response;

  logic       start2, abort2, rec_ready2;
  logic       busy2, done2, rec_valid2;
  logic [3:0] cut_in2, rec_vector2, cut_out2, rec_response2;

  int n_vec = 0;
  int n_err = 0;

`ifdef SWEEP_SIGNATURE_EN
  logic [15:0] signature, signature2, sig_model;
  logic        sig_valid, sig_valid2;

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [15:0] d);
    logic [15:0] t;
    t = {s[14:0], 1'b0};
    if (s[15]) t = t ^ 16'h1021;
    return t ^ d;
  endfunction
`endif

  trojan_sweep_sequencer #(.N_WIDTH(4), .OUT_WIDTH(1), .SETTLE_CYCLES(1)) dut (
    .CK(CK), .reset(reset), .start(start), .abort(abort), .busy(busy), .done(done),
    .cut_in(cut_in), .cut_out(cut_out), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .rec_vector(rec_vector), .rec_response(rec_response)
`ifdef SWEEP_SIGNATURE_EN
    , .signature(signature), .sig_valid(sig_valid)
`endif
  );

  trojan_sweep_sequencer #(.N_WIDTH(4), .OUT_WIDTH(4), .SETTLE_CYCLES(3)) dut2 (
    .CK(CK), .reset(reset), .start(start2), .abort(abort2), .busy(busy2), .done(done2),
    .cut_in(cut_in2), .cut_out(cut_out2), .rec_valid(rec_valid2), .rec_ready(rec_ready2),
    .rec_vector(rec_vector2), .rec_response(rec_response2)
`ifdef SWEEP_SIGNATURE_EN
    , .signature(signature2), .sig_valid(sig_valid2)
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  assign cut_out = &cut_in;
  always @(posedge CK) cut_out2 <= cut_in2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on dut; optionally hold rec_ready low for stall_len cycles on stall_vec.
  task automatic run_sweep(input int stall_vec, input int stall_len);
    int exp_v, cyc, stall_cnt, extra;
    bit got_done;
    exp_v = 0; cyc = 0; stall_cnt = 0; got_done = 0;
    extra = (stall_vec >= 0) ? stall_len : 0;
`ifdef SWEEP_SIGNATURE_EN
    sig_model = 16'hFFFF;
`endif
    start = 1'b1;
    @(posedge CK); @(negedge CK);
    start = 1'b0;
    while (!got_done && cyc < 400) begin
      if (rec_valid) begin
        if (exp_v == stall_vec && stall_cnt < stall_len) begin
          rec_ready = 1'b0;
          chk("stall_vector", 32'(rec_vector), 32'(exp_v));
          chk("stall_cut_in", 32'(cut_in), 32'(exp_v));
          stall_cnt++;
        end else begin
          rec_ready = 1'b1;
          chk("rec_vector", 32'(rec_vector), 32'(exp_v));
          chk("rec_response", 32'(rec_response), 32'(exp_v == 15));
          // vector k becomes valid 3k+2 edges after the start edge
          chk("rec_time", 32'(cyc), 32'(exp_v * 3 + 2 + ((stall_vec >= 0 && exp_v >= stall_vec) ? stall_len : 0)));
          $display("rec vec=%h resp=%0d t=%0d", rec_vector, rec_response, cyc);
`ifdef SWEEP_SIGNATURE_EN
          sig_model = misr_model(sig_model, (exp_v == 15) ? 16'h0001 : 16'h0000);
`endif
          exp_v++;
        end
      end
      @(posedge CK); cyc++; @(negedge CK);
      if (done) got_done = 1'b1;
    end
    chk("rec_count", 32'(exp_v), 32'd16);
    chk("done_time", 32'(cyc), 32'(49 + extra));
    chk("busy_at_done", 32'(busy), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("sig_valid_at_done", 32'(sig_valid), 32'd1);
    chk("signature", 32'(signature), 32'(sig_model));
`endif
    @(posedge CK); @(negedge CK);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, exp_v;
    bit seen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; rec_ready = 1'b1;
    start2 = 1'b0; abort2 = 1'b0; rec_ready2 = 1'b1;
    repeat (3) @(posedge CK);
    @(negedge CK);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_cut_in", 32'(cut_in), 32'd0);
    chk("rst_vector", 32'(rec_vector), 32'd0);
    chk("rst_response", 32'(rec_response), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("rst_sig_valid", 32'(sig_valid), 32'd0);
`endif
    reset = 1'b0;
    @(posedge CK); @(negedge CK);

    // full sweep, AND-reduce CUT
    run_sweep(-1, 0);

    // start together with abort in IDLE stays idle (and clears sig_valid)
    start = 1'b1; abort = 1'b1;
    @(posedge CK); @(negedge CK);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_idle", 32'(busy), 32'd0);
`ifdef SWEEP_SIGNATURE_EN
    chk("abort_clears_sig", 32'(sig_valid), 32'd0);
`endif
    @(posedge CK); @(negedge CK);
    chk("start_abort_stay", 32'(busy), 32'd0);

    // backpressure on vector 0011 for 5 cycles
    run_sweep(3, 5);

    // abort during SETTLE of vector 0110
    start = 1'b1;
    @(posedge CK); @(negedge CK);
    start = 1'b0;
    cyc = 0;
    while (!(cut_in == 4'd6 && !rec_valid) && cyc < 100) begin
      @(posedge CK); @(negedge CK); cyc++;
    end
    chk("abort_reach", 32'(cut_in), 32'd6);
    abort = 1'b1;
    @(posedge CK); @(negedge CK);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rec_valid), 32'd0);
    chk("abort_cut_in", 32'(cut_in), 32'd0);
    seen = done;
    repeat (5) begin
      @(posedge CK); @(negedge CK);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_sweep(-1, 0);

    // reset while vector 1010 waits in EMIT
    start = 1'b1;
    @(posedge CK); @(negedge CK);
    start = 1'b0;
    cyc = 0;
    while (!(rec_valid && rec_vector == 4'd10) && cyc < 100) begin
      @(posedge CK); @(negedge CK); cyc++;
    end
    rec_ready = 1'b0;
    chk("rst_reach", 32'(rec_vector), 32'd10);
    reset = 1'b1; start = 1'b1;
    @(posedge CK); @(negedge CK);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_valid", 32'(rec_valid), 32'd0);
    chk("midrst_cut_in", 32'(cut_in), 32'd0);
    chk("midrst_vector", 32'(rec_vector), 32'd0);
    @(posedge CK); @(negedge CK);
    chk("midrst_start_ignored", 32'(busy), 32'd0);
    reset = 1'b0; start = 1'b0; rec_ready = 1'b1;
    @(posedge CK); @(negedge CK);
    chk("after_rst_idle", 32'(busy), 32'd0);

    // SETTLE_CYCLES=3 with a registered CUT: 5-cycle period, response equals vector
    start2 = 1'b1;
    @(posedge CK); @(negedge CK);
    start2 = 1'b0;
    cyc = 0; exp_v = 0; seen = 1'b0;
    while (!seen && cyc < 400) begin
      if (rec_valid2) begin
        chk("s3_vector", 32'(rec_vector2), 32'(exp_v));
        chk("s3_response", 32'(rec_response2), 32'(exp_v));
        chk("s3_time", 32'(cyc), 32'(exp_v * 5 + 4));
        $display("rec2 vec=%h resp=%h t=%0d", rec_vector2, rec_response2, cyc);
        exp_v++;
      end
      @(posedge CK); cyc++; @(negedge CK);
      if (done2) seen = 1'b1;
    end
    chk("s3_count", 32'(exp_v), 32'd16);
    chk("s3_done_time", 32'(cyc), 32'd81);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
